// File: rtl/osc_capture_ctrl_if.sv
// Host-side and bank-side signal bundle for the oscillator-bank capture sequencer.
interface osc_capture_ctrl_if #(
    parameter int unsigned ADD_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 144
);
    logic                  START;
    logic                  ABORT;
    logic [7:0]            RUNS;
    logic                  BUSY;
    logic                  DONE;
    logic                  BANK_RECORDING;
    logic [ADD_WIDTH-1:0]  BANK_ADDRESS;
    logic [DATA_WIDTH-1:0] BANK_DATA;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic                  OUT_LAST;
    logic [7:0]            OUT_RUN;

    // Sequencer view: drives the bank controls and the sample stream.
    modport master (
        input  START, ABORT, RUNS, BANK_DATA, OUT_READY,
        output BUSY, DONE, BANK_RECORDING, BANK_ADDRESS, OUT_DATA, OUT_VALID, OUT_LAST, OUT_RUN
    );

    // Host/bank view.
    modport slave (
        output START, ABORT, RUNS, BANK_DATA, OUT_READY,
        input  BUSY, DONE, BANK_RECORDING, BANK_ADDRESS, OUT_DATA, OUT_VALID, OUT_LAST, OUT_RUN
    );
endinterface

// File: rtl/osc_capture_ctrl.sv
// Capture sequencer: arms the oscillator bank, times the capture window, then reads the
// sample memory back address by address and streams each sample over valid/ready.
module osc_capture_ctrl #(
    parameter int unsigned ADD_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH     = 144,
    parameter int unsigned NUM_SAMPLES    = 16384,
    parameter int unsigned CAPTURE_CYCLES = 200000,
    parameter int unsigned READ_LATENCY   = 3
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    osc_capture_ctrl_if.master     bus
);

    localparam int unsigned         LatW     = $clog2(READ_LATENCY + 1);
    localparam logic [31:0]         CapLoad  = 32'(CAPTURE_CYCLES);
    localparam logic [LatW-1:0]     LatLoad  = LatW'(READ_LATENCY);
    localparam logic [ADD_WIDTH:0]  LastIdx  = (ADD_WIDTH + 1)'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        StIdle, StArm, StCapture, StRdWait, StPresent, StFinish
    } state_e;

    state_e                r_state,     w_state_nxt;
    logic [7:0]            r_runs,      w_runs_nxt;
    logic [7:0]            r_run_idx,   w_run_idx_nxt;
    logic [31:0]           r_win_cnt,   w_win_cnt_nxt;
    logic [LatW-1:0]       r_lat_cnt,   w_lat_cnt_nxt;
    // One bit wider than the address so a full 2^ADD_WIDTH readout does not wrap.
    logic [ADD_WIDTH:0]    r_idx,       w_idx_nxt;
    logic [DATA_WIDTH-1:0] r_out_data,  w_out_data_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic                  r_out_last,  w_out_last_nxt;
    logic                  w_more_runs;

    assign w_more_runs = ({1'b0, r_run_idx} + 9'd1) < {1'b0, r_runs};

    // Next-state and datapath updates; ABORT overrides whatever the state decided.
    always_comb begin
        w_state_nxt     = r_state;
        w_runs_nxt      = r_runs;
        w_run_idx_nxt   = r_run_idx;
        w_win_cnt_nxt   = r_win_cnt;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_idx_nxt       = r_idx;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;

        unique case (r_state)
            StIdle: begin
                if (bus.START) begin
                    w_runs_nxt    = (bus.RUNS == 8'd0) ? 8'd1 : bus.RUNS;
                    w_run_idx_nxt = 8'd0;
                    w_state_nxt   = StArm;
                end
            end
            StArm: begin
                w_win_cnt_nxt = CapLoad;
                w_state_nxt   = StCapture;
            end
            StCapture: begin
                w_win_cnt_nxt = r_win_cnt - 32'd1;
                if (r_win_cnt <= 32'd1) begin
                    w_idx_nxt     = '0;
                    w_lat_cnt_nxt = LatLoad;
                    w_state_nxt   = StRdWait;
                end
            end
            StRdWait: begin
                w_lat_cnt_nxt = r_lat_cnt - LatW'(1);
                if (r_lat_cnt <= LatW'(1)) begin
                    w_out_data_nxt  = bus.BANK_DATA;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = (r_idx == LastIdx);
                    w_state_nxt     = StPresent;
                end
            end
            StPresent: begin
                if (bus.OUT_READY) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    if (!r_out_last) begin
                        w_idx_nxt     = r_idx + (ADD_WIDTH + 1)'(1);
                        w_lat_cnt_nxt = LatLoad;
                        w_state_nxt   = StRdWait;
                    end else if (w_more_runs) begin
                        w_run_idx_nxt = r_run_idx + 8'd1;
                        w_state_nxt   = StArm;
                    end else begin
                        w_state_nxt   = StFinish;
                    end
                end
            end
            StFinish: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        if (bus.ABORT) begin
            w_state_nxt     = StIdle;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_state     <= StIdle;
            r_runs      <= 8'd0;
            r_run_idx   <= 8'd0;
            r_win_cnt   <= 32'd0;
            r_lat_cnt   <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_runs      <= w_runs_nxt;
            r_run_idx   <= w_run_idx_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    assign bus.BUSY           = (r_state != StIdle);
    assign bus.DONE           = (r_state == StFinish);
    assign bus.BANK_RECORDING = (r_state == StArm);
    assign bus.BANK_ADDRESS   = r_idx[ADD_WIDTH-1:0];
    assign bus.OUT_DATA       = r_out_data;
    assign bus.OUT_VALID      = r_out_valid;
    assign bus.OUT_LAST       = r_out_last;
    assign bus.OUT_RUN        = r_run_idx;

endmodule

// File: tb/tb_osc_capture_ctrl.sv
// Randomized bench for osc_capture_ctrl: a latency-exact bank model, an expected-sample
// queue built from the run/sample counts, and a negedge monitor scoring every transfer.
module tb_osc_capture_ctrl;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 16;
    localparam int unsigned NS  = 4;
    localparam int unsigned CAP = 20;
    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [7:0]    run;
    } smp_t;

    logic CLOCK = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    smp_t exp_q[$];
    smp_t mon_e;
    int   arm_cyc[$];
    int   arm_cnt, done_cnt, xfer_cnt, fv_cyc;
    bit   fv_seen, rdy_rand, hold_prev, rec_prev;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic [7:0]    hold_run;

    osc_capture_ctrl_if #(.ADD_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    osc_capture_ctrl #(
        .ADD_WIDTH      (AW),
        .DATA_WIDTH     (DW),
        .NUM_SAMPLES    (NS),
        .CAPTURE_CYCLES (CAP),
        .READ_LATENCY   (LAT)
    ) u_dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Bank: data for an address becomes valid exactly LAT edges after the address changes.
    logic [AW-1:0] bank_p1, bank_p2;
    always @(posedge CLOCK) begin
        bank_p1 <= bus.BANK_ADDRESS;
        bank_p2 <= bank_p1;
    end
    assign bus.BANK_DATA = DW'(bank_p2) + DW'(100);

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Monitor: scores transfers, enforces hold-under-backpressure, counts pulses.
    always @(negedge CLOCK) begin
        if (RESET === 1'b1 && bus.ABORT === 1'b0) begin
            if (hold_prev) begin
                check_val("hold_valid", 64'(bus.OUT_VALID), 64'(1));
                check_val("hold_data", 64'(bus.OUT_DATA), 64'(hold_data));
                check_val("hold_last", 64'(bus.OUT_LAST), 64'(hold_last));
                check_val("hold_run", 64'(bus.OUT_RUN), 64'(hold_run));
            end
            hold_prev = bus.OUT_VALID && !bus.OUT_READY;
            hold_data = bus.OUT_DATA;
            hold_last = bus.OUT_LAST;
            hold_run  = bus.OUT_RUN;
            if (bus.OUT_VALID && !fv_seen) begin
                fv_seen = 1'b1;
                fv_cyc  = cyc;
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("extra_xfer", 64'(bus.OUT_DATA), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("xfer_data", 64'(bus.OUT_DATA), 64'(mon_e.data));
                    check_val("xfer_last", 64'(bus.OUT_LAST), 64'(mon_e.last));
                    check_val("xfer_run", 64'(bus.OUT_RUN), 64'(mon_e.run));
                end
            end
        end else begin
            hold_prev = 1'b0;
        end
        if (bus.BANK_RECORDING) begin
            check_val("rec_width", 64'(rec_prev), 64'(0));
            arm_cnt++;
            arm_cyc.push_back(cyc);
        end
        rec_prev = bus.BANK_RECORDING;
        if (bus.DONE) done_cnt++;
    end

    // OUT_READY: held high or toggled randomly, updated just after each edge.
    initial begin
        bus.OUT_READY = 1'b1;
        forever begin
            @(posedge CLOCK);
            #1;
            bus.OUT_READY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic clear_stats();
        arm_cnt  = 0;
        done_cnt = 0;
        xfer_cnt = 0;
        fv_seen  = 1'b0;
        arm_cyc.delete();
    endtask

    task automatic load_expect(input int n_runs);
        exp_q.delete();
        for (int r = 0; r < n_runs; r++) begin
            for (int i = 0; i < int'(NS); i++) begin
                exp_q.push_back('{data: DW'(i + 100), last: (i == int'(NS) - 1), run: 8'(r)});
            end
        end
    endtask

    // Drives START for one edge; returns the cycle count just after that edge.
    task automatic pulse_start(input logic [7:0] runs, output int t_edge);
        @(posedge CLOCK);
        #1;
        bus.START = 1'b1;
        bus.RUNS  = runs;
        @(posedge CLOCK);
        #1;
        bus.START = 1'b0;
        t_edge    = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.BUSY && k < 5000) begin
            @(posedge CLOCK);
            #1;
            k++;
        end
        check_val(tag, 64'(k >= 5000), 64'(0));
    endtask

    task automatic run_seq(input logic [7:0] runs, input bit rnd, input bit poke);
        int n_runs = (runs == 8'd0) ? 1 : int'(runs);
        int t0;
        clear_stats();
        load_expect(n_runs);
        rdy_rand = rnd;
        pulse_start(runs, t0);
        check_val("busy_after_start", 64'(bus.BUSY), 64'(1));
        check_val("rec_after_start", 64'(bus.BANK_RECORDING), 64'(1));
        @(posedge CLOCK);
        #1;
        check_val("rec_low_t1", 64'(bus.BANK_RECORDING), 64'(0));
        if (poke) begin
            repeat (5) @(posedge CLOCK);
            #1;
            bus.START = 1'b1;
            @(posedge CLOCK);
            #1;
            bus.START = 1'b0;
        end
        wait_idle("seq_timeout");
        repeat (2) @(posedge CLOCK);
        #1;
        check_val("queue_drained", 64'(exp_q.size()), 64'(0));
        check_val("arm_pulses", 64'(arm_cnt), 64'(n_runs));
        check_val("done_pulses", 64'(done_cnt), 64'(1));
        check_val("busy_end", 64'(bus.BUSY), 64'(0));
        check_val("first_valid_lat", 64'(fv_cyc - t0), 64'(CAP + LAT + 1));
        if (n_runs >= 2) begin
            check_val("arm_gap_ok", 64'((arm_cyc[1] - arm_cyc[0]) >= int'(CAP) + 1), 64'(1));
        end
        rdy_rand = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, 64'(bus.BUSY), 64'(0));
        check_val({tag, "_done"}, 64'(bus.DONE), 64'(0));
        check_val({tag, "_rec"}, 64'(bus.BANK_RECORDING), 64'(0));
        check_val({tag, "_valid"}, 64'(bus.OUT_VALID), 64'(0));
        check_val({tag, "_last"}, 64'(bus.OUT_LAST), 64'(0));
        check_val({tag, "_addr"}, 64'(bus.BANK_ADDRESS), 64'(0));
        check_val({tag, "_data"}, 64'(bus.OUT_DATA), 64'(0));
        check_val({tag, "_run"}, 64'(bus.OUT_RUN), 64'(0));
    endtask

    initial begin
        int t0;
        int k;
        RESET     = 1'b0;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.RUNS  = 8'd0;
        rdy_rand  = 1'b0;
        clear_stats();
        repeat (3) @(posedge CLOCK);
        #1;
        check_reset_outputs("reset");
        RESET = 1'b1;

        run_seq(8'd1, 1'b0, 1'b0);
        run_seq(8'd1, 1'b1, 1'b0);
        run_seq(8'd2, 1'b1, 1'b0);
        run_seq(8'd0, 1'b1, 1'b1);
        for (int it = 0; it < 3; it++) begin
            run_seq(8'($urandom_range(1, 3)), 1'b1, 1'b0);
        end

        // ABORT while the third sample (address 2) is being read.
        clear_stats();
        load_expect(1);
        pulse_start(8'd1, t0);
        k = 0;
        while (xfer_cnt < 2 && k < 500) begin
            @(posedge CLOCK);
            #1;
            k++;
        end
        check_val("abort_reach_timeout", 64'(k >= 500), 64'(0));
        check_val("abort_addr", 64'(bus.BANK_ADDRESS), 64'(2));
        bus.ABORT = 1'b1;
        @(posedge CLOCK);
        #1;
        bus.ABORT = 1'b0;
        check_val("abort_busy", 64'(bus.BUSY), 64'(0));
        check_val("abort_valid", 64'(bus.OUT_VALID), 64'(0));
        check_val("abort_last", 64'(bus.OUT_LAST), 64'(0));
        repeat (30) @(posedge CLOCK);
        #1;
        check_val("abort_no_done", 64'(done_cnt), 64'(0));
        check_val("abort_no_rearm", 64'(arm_cnt), 64'(1));
        check_val("abort_stay_idle", 64'(bus.BUSY), 64'(0));
        exp_q.delete();
        run_seq(8'd1, 1'b1, 1'b0);

        // RESET pulse in the middle of the capture window.
        clear_stats();
        load_expect(2);
        pulse_start(8'd2, t0);
        repeat (10) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        check_reset_outputs("midreset");
        repeat (40) @(posedge CLOCK);
        #1;
        check_val("midreset_no_rearm", 64'(arm_cnt), 64'(1));
        check_val("midreset_no_done", 64'(done_cnt), 64'(0));
        check_val("midreset_idle", 64'(bus.BUSY), 64'(0));
        exp_q.delete();
        run_seq(8'd2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/osc_capture_ctrl.md
# osc_capture_ctrl

Sequencer for the oscillator-bank capture datapath. It arms one or more capture runs on the bank and times each run's capture window. After each window it reads the bank's sample memory back address by address and streams every sample out on a valid/ready interface to the host link. The block sits between the host command logic and the oscillator bank, and is the only driver of the bank's RECORDING and ADDRESS inputs.

## Interface
- ADD_WIDTH, 16: bank sample-memory address width.
- DATA_WIDTH, 144: bank readout data width.
- NUM_SAMPLES, 16384: samples read back per run. Range 1..2^ADD_WIDTH.
- CAPTURE_CYCLES, 200000: CLOCK cycles to wait after arming before readout. Must be ≥1 and fit 32 bits.
- READ_LATENCY, 3: CLOCK edges from a BANK_ADDRESS change to valid BANK_DATA. Must be ≥1.

- CLOCK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low.
- START  in  1  begin a sequence; sampled only in IDLE.
- ABORT  in  1  terminate any sequence; return to IDLE.
- RUNS  in  8  runs per sequence, latched at START. 0 is treated as 1.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse after the last sample of the last run transfers.
- BANK_RECORDING  out  1  one-cycle arm pulse to the bank.
- BANK_ADDRESS  out  ADD_WIDTH  readout address to the bank.
- BANK_DATA  in  DATA_WIDTH  readout data from the bank.
- OUT_DATA  out  DATA_WIDTH  sample to host.
- OUT_VALID  out  1  OUT_DATA/OUT_LAST/OUT_RUN valid.
- OUT_READY  in  1  host accepts; a transfer occurs when OUT_VALID && OUT_READY at an edge.
- OUT_LAST  out  1  high with the last sample of a run.
- OUT_RUN  out  8  zero-based run index of the current sample.

## Operation
- States: IDLE, ARM, CAPTURE, RD_WAIT, PRESENT, FINISH.
- IDLE:
  - If START=1, latch RUNS (0 becomes 1), clear the run index and go to ARM.
- ARM:
  - BANK_RECORDING=1 for exactly this cycle.
  - Load the 32-bit window counter with CAPTURE_CYCLES and go to CAPTURE.
- CAPTURE:
  - Decrement the window counter each cycle.
  - When it reaches 1: clear the sample index, set BANK_ADDRESS=0, load the latency counter with READ_LATENCY, go to RD_WAIT.
- RD_WAIT:
  - Decrement the latency counter each cycle.
  - At its last cycle, register BANK_DATA into OUT_DATA, set OUT_VALID=1, set OUT_LAST=(index==NUM_SAMPLES-1), go to PRESENT.
- PRESENT:
  - Hold OUT_DATA, OUT_LAST and OUT_RUN stable until a transfer.
  - On transfer with a non-last sample: OUT_VALID=0, increment the index, set BANK_ADDRESS=index+1, reload the latency counter, go to RD_WAIT.
  - On transfer with the last sample and more runs remaining: increment the run index, go to ARM.
  - Otherwise go to FINISH.
- FINISH:
  - DONE=1 for one cycle, then IDLE.
- Widths: the sample index is ADD_WIDTH+1 bits, so NUM_SAMPLES=2^ADD_WIDTH does not wrap. BANK_ADDRESS is the index truncated to ADD_WIDTH. The run index is 8 bits.
- START outside IDLE is ignored.
- ABORT has priority over every transition except RESET:
  - Next state is IDLE.
  - OUT_VALID, OUT_LAST, BANK_RECORDING and DONE are 0 from that edge.
  - DONE does not pulse.
- Reset values: state IDLE; BUSY, DONE, BANK_RECORDING, OUT_VALID, OUT_LAST = 0; BANK_ADDRESS, OUT_DATA, OUT_RUN = 0; all counters 0.
- RESET mid-sequence behaves as ABORT plus clearing OUT_DATA. The bank is reset by its own RESET connection.

## Timing
- START=1 at edge t (in IDLE): BUSY and BANK_RECORDING high after t; BANK_RECORDING low after t+1.
- First BANK_ADDRESS=0 presented after edge t+1+CAPTURE_CYCLES.
- BANK_ADDRESS changes at edge E: BANK_DATA is sampled at edge E+READ_LATENCY, and OUT_VALID is high after that edge.
- Transfer at edge T: OUT_VALID low after T. The next address is presented at T, and the next OUT_VALID rises after T+READ_LATENCY.
- Peak throughput: one sample per READ_LATENCY+1 cycles with OUT_READY held high.
- OUT_VALID is never withdrawn without a transfer, except on ABORT or RESET.
- Last-sample transfer at T with runs remaining: BANK_RECORDING pulses in the cycle after T.
- Last-sample transfer at T on the final run: DONE pulses in the cycle after T, and BUSY drops after T+1.

## Test plan
- Single run (NUM_SAMPLES=4, CAPTURE_CYCLES=20, READ_LATENCY=3, bank model returning data=address+100, OUT_READY=1):
  - one BANK_RECORDING pulse;
  - OUT_DATA 100,101,102,103;
  - OUT_LAST only on 103;
  - first OUT_VALID 24 cycles after the START edge;
  - DONE pulse once; BUSY low afterwards.
- Backpressure (same setup, OUT_READY toggled pseudo-randomly):
  - OUT_DATA, OUT_LAST and OUT_RUN stable while OUT_VALID && !OUT_READY;
  - same 4 values in order, none lost or duplicated.
- RUNS=2:
  - two BANK_RECORDING pulses ≥21 cycles apart;
  - 8 samples total, OUT_RUN 0,0,0,0,1,1,1,1;
  - OUT_LAST on the 4th and 8th sample;
  - a single DONE.
- RUNS=0 → behaves as RUNS=1. START while BUSY → ignored, no extra arm pulse.
- ABORT during RD_WAIT of sample 2:
  - IDLE next cycle; OUT_VALID=0; no DONE;
  - a fresh START runs a full sequence from address 0.
- RESET=0 for one cycle mid-CAPTURE:
  - all outputs at reset values next cycle;
  - no BANK_RECORDING until a new START.
